// File: rtl/port_share_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : port_share_pkg                                              |
// | Description : Shared types and helpers for the port-sharing arbiter:      |
// |               FSM state encoding and an index-width helper.               |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package port_share_pkg;

  // Arbiter FSM: IDLE picks a requester, BUSY streams its burst.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Width of an index into n items. It is never narrower than one bit, so a
  // vector declared with it is always legal.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_share_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_pick                                                     |
// | Description : Combinational round-robin picker. Returns the first set     |
// |               request bit found by scanning from ptr upward, modulo N_REQ.|
// | Ports       : req [N_REQ]  request vector                                 |
// |               ptr [IW]     scan start index (must be < N_REQ)             |
// |               any          at least one request present                   |
// |               idx [IW]     chosen index (valid when any=1)                |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module rr_pick
  import port_share_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic                    any,
  output logic [idx_w(N_REQ)-1:0] idx
);

  localparam int               c_iw = idx_w(N_REQ);
  localparam logic [c_iw:0]    c_n  = (c_iw+1)'(N_REQ);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [c_iw-1:0]    w_off;
  logic [c_iw:0]      w_sum;
  logic               w_found;

  always_comb begin
    // Rotate so that bit ptr lands at position 0; the doubled vector makes
    // the rotation a plain part-select.
    w_dbl   = {req, req};
    w_rot   = w_dbl[ptr +: N_REQ];
    w_off   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_rot[i] && !w_found) begin
        w_off   = c_iw'(i);
        w_found = 1'b1;
      end
    end
    // Rotate back: ptr + offset, wrapped into 0..N_REQ-1.
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= c_n) begin
      w_sum = w_sum - c_n;
    end
    any = |req;
    idx = w_sum[c_iw-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/port_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : port_share_arbiter                                          |
// | Description : Round-robin, burst-aware arbiter sharing one downstream     |
// |               port between N_REQ requesters, with a registered output     |
// |               stage and forced release after MAX_BURST beats.             |
// | Ports       : clk, rst_n            clock / async active-low reset        |
// |               req_valid/last [N]    per-requester beat valid / last       |
// |               req_data [N*DATA_W]   packed payloads, i at [i*DATA_W+:W]   |
// |               req_ready [N]         per-requester accept (one-hot or 0)   |
// |               out_valid/ready       registered downstream handshake       |
// |               out_data/last/src     registered beat, last, owner index    |
// |               burst_cut             pulse: grant force-released           |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module port_share_arbiter
  import port_share_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic [idx_w(N_REQ)-1:0] out_src,
  output logic                    burst_cut
);

  localparam int                c_iw        = idx_w(N_REQ);
  localparam int                c_cw        = $clog2(MAX_BURST + 1);
  localparam logic [c_cw-1:0]   c_last_beat = c_cw'(MAX_BURST - 1);
  localparam logic [c_iw-1:0]   c_top_idx   = c_iw'(N_REQ - 1);

  state_e              state_q,     state_d;
  logic [c_iw-1:0]     gnt_q,       gnt_d;
  logic [c_iw-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [c_cw-1:0]     beat_cnt_q,  beat_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q,  out_data_d;
  logic                out_last_q,  out_last_d;
  logic [c_iw-1:0]     out_src_q,   out_src_d;
  logic                burst_cut_q, burst_cut_d;

  logic                w_any;
  logic [c_iw-1:0]     w_pick;
  logic                w_slot_free;
  logic                w_gnt_last;
  logic                w_accept;
  logic                w_forced;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (w_any),
    .idx (w_pick)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    burst_cut_d = 1'b0;
    req_ready   = '0;

    // The output register can take a new beat when empty or draining now.
    w_slot_free = !out_valid_q || out_ready;
    w_gnt_last  = req_last[gnt_q];
    w_accept    = (state_q == BUSY) && req_valid[gnt_q] && w_slot_free;
    // Beat MAX_BURST without a real last ends the burst by force.
    w_forced    = (beat_cnt_q == c_last_beat) && !w_gnt_last;

    if (state_q == BUSY) begin
      req_ready[gnt_q] = w_slot_free;
    end

    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = req_data[gnt_q*DATA_W +: DATA_W];
      out_last_d  = w_gnt_last || w_forced;
      out_src_d   = gnt_q;
      burst_cut_d = w_forced;
      beat_cnt_d  = beat_cnt_q + 1'b1;
      if (w_gnt_last || w_forced) begin
        state_d    = IDLE;
        rr_ptr_d   = (gnt_q == c_top_idx) ? '0 : gnt_q + 1'b1;
        beat_cnt_d = '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == IDLE) && w_any) begin
      gnt_d   = w_pick;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      burst_cut_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      burst_cut_q <= burst_cut_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign burst_cut = burst_cut_q;

endmodule
`default_nettype wire

// File: tb/tb_port_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_port_share_arbiter                                       |
// | Description : Self-checking bench for port_share_arbiter (N_REQ=4,       |
// |               DATA_W=8, MAX_BURST=4). A cycle model checks every output  |
// |               each cycle; directed scenarios pin beat order literally.   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_port_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           burst_cut;

  always #5 clk = ~clk;

  port_share_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .burst_cut (burst_cut)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- requester stimulus: one beat queue per requester
  logic [8:0] src_q [N][$];   // {last, data}
  logic [N-1:0] hold = '0;    // forces req_valid low while set
  logic [N-1:0] acc  = '0;    // handshake seen at last negedge

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    #2;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      req_valid[i] = (src_q[i].size() > 0) && !hold[i];
      if (src_q[i].size() > 0) begin
        req_data[i*W +: W] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_data[i*W +: W] = '0;
        req_last[i]        = 1'b0;
      end
    end
  end

  // ---------------- behavioural model
  int         m_owner = -1;   // requester holding the port, -1 when none
  int         m_ptr   = 0;    // first requester to consider next time
  int         m_beats = 0;    // beats already sent in the current burst
  bit         m_ov    = 0;
  logic [7:0] m_od    = '0;
  bit         m_ol    = 0;
  int         m_os    = 0;
  bit         m_cut   = 0;

  typedef struct packed {
    logic [1:0] s;
    logic [7:0] d;
    logic       l;
    logic       c;
    int         cyc;
  } beat_t;
  beat_t blog[$];

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    bit           take, lst, cut;
    int           start_owner;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_beats = 0;
      m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_cut = 0;
    end
    e_ready = '0;
    if (rst_n && m_owner >= 0 && (!m_ov || out_ready)) e_ready[m_owner] = 1'b1;

    chk("req_ready", req_ready, e_ready);
    chk("out_valid", out_valid, m_ov);
    chk("burst_cut", burst_cut, m_cut);
    if (m_ov || !rst_n) begin
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("out_src",  out_src,  m_os);
    end

    acc = req_valid & req_ready;
    if (rst_n && out_valid && out_ready)
      blog.push_back('{s: out_src, d: out_data, l: out_last, c: burst_cut, cyc: cyc_n});

    if (rst_n) begin
      start_owner = m_owner;
      take = (m_owner >= 0) && req_valid[m_owner] && e_ready[m_owner];
      m_cut = 0;
      if (take) begin
        lst   = req_last[m_owner];
        cut   = (m_beats + 1 == MB) && !lst;
        m_ov  = 1;
        m_od  = req_data[m_owner*W +: W];
        m_ol  = lst || cut;
        m_os  = m_owner;
        m_cut = cut;
        if (lst || cut) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_beats = 0;
        end else begin
          m_beats = m_beats + 1;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (start_owner < 0 && req_valid != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
    end
  end

  // ---------------- scenario helpers
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
  endtask

  task automatic drain(input string nm);
    int  k;
    bit  busy;
    k = 0;
    busy = 1;
    while (busy && k < 200) begin
      busy = out_valid;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1;
      if (busy) begin cyc(1); k++; end
    end
    chk({nm, "_timeout"}, (k >= 200) ? 1 : 0, 0);
    cyc(2);
  endtask

  task automatic wait_ov(input string nm);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin cyc(1); k++; end
    chk({nm, "_timeout"}, (k >= 50) ? 1 : 0, 0);
  endtask

  task automatic lg(input string nm, input int i, input int s, input int d,
                    input int l, input int c);
    if (i < blog.size()) begin
      chk({nm, "_src"},  blog[i].s, s);
      chk({nm, "_data"}, blog[i].d, d);
      chk({nm, "_last"}, blog[i].l, l);
      chk({nm, "_cut"},  blog[i].c, c);
    end else begin
      chk({nm, "_count"}, blog.size(), i + 1);
    end
  endtask

  task automatic zeros(input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_data"},  out_data,  0);
    chk({nm, "_last"},  out_last,  0);
    chk({nm, "_src"},   out_src,   0);
    chk({nm, "_cut"},   burst_cut, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Watchdog against a stuck run.
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    cyc(3);
    zeros("reset");
    rst_n = 1'b1;
    cyc(2);

    // Fairness: single-beat bursts from all four, requester 0 twice.
    blog.delete();
    push(0, 8'h10, 1); push(1, 8'h11, 1); push(2, 8'h12, 1);
    push(3, 8'h13, 1); push(0, 8'h14, 1);
    drain("fair");
    lg("fair0", 0, 0, 'h10, 1, 0);
    lg("fair1", 1, 1, 'h11, 1, 0);
    lg("fair2", 2, 2, 'h12, 1, 0);
    lg("fair3", 3, 3, 'h13, 1, 0);
    lg("fair4", 4, 0, 'h14, 1, 0);
    for (int i = 1; i < 5; i++)
      if (i < blog.size()) chk("fair_gap", blog[i].cyc - blog[i-1].cyc, 2);

    // Burst from requester 2; requester 1 arrives after the grant.
    blog.delete();
    push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
    cyc(2);
    push(1, 8'h51, 1);
    drain("burst");
    lg("burst0", 0, 2, 'hA1, 0, 0);
    lg("burst1", 1, 2, 'hA2, 0, 0);
    lg("burst2", 2, 2, 'hA3, 1, 0);
    lg("burst3", 3, 1, 'h51, 1, 0);

    // Forced cut at beat 4; requester 3 gets the port, then 0 resumes.
    blog.delete();
    for (int i = 0; i < 6; i++) push(0, 8'hB0 + 8'(i), (i == 5) ? 1'b1 : 1'b0);
    cyc(2);
    push(3, 8'h33, 1);
    drain("cut");
    lg("cut0", 0, 0, 'hB0, 0, 0);
    lg("cut2", 2, 0, 'hB2, 0, 0);
    lg("cut3", 3, 0, 'hB3, 1, 1);
    lg("cut4", 4, 3, 'h33, 1, 0);
    lg("cut5", 5, 0, 'hB4, 0, 0);
    lg("cut6", 6, 0, 'hB5, 1, 0);

    // Backpressure for three cycles, then a mid-burst valid gap.
    blog.delete();
    push(1, 8'hC0, 0); push(1, 8'hC1, 0); push(1, 8'hC2, 0); push(1, 8'hC3, 1);
    wait_ov("bp");
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_data",  out_data,     'hC0);
      chk("bp_hold_ready", req_ready[1], 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    cyc(1);
    chk("bp_reload_valid", out_valid, 1);
    chk("bp_reload_data",  out_data,  'hC1);
    hold[1] = 1'b1;
    cyc(2);
    hold[1] = 1'b0;
    drain("bp");
    lg("bp0", 0, 1, 'hC0, 0, 0);
    lg("bp1", 1, 1, 'hC1, 0, 0);
    lg("bp2", 2, 1, 'hC2, 0, 0);
    lg("bp3", 3, 1, 'hC3, 1, 0);

    // Wrap: bring the pointer to 3, then requesters 1 and 3 together.
    blog.delete();
    push(2, 8'h62, 1);
    drain("wrap_a");
    push(1, 8'h71, 1); push(3, 8'h73, 1);
    drain("wrap_b");
    lg("wrap0", 0, 2, 'h62, 1, 0);
    lg("wrap1", 1, 3, 'h73, 1, 0);
    lg("wrap2", 2, 1, 'h71, 1, 0);

    // Reset mid-burst, then the pointer must be back at 0.
    push(0, 8'hD0, 0); push(0, 8'hD1, 0); push(0, 8'hD2, 0); push(0, 8'hD3, 1);
    wait_ov("mid_rst");
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    zeros("mid_rst");
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    blog.delete();
    push(1, 8'h81, 1); push(3, 8'h83, 1);
    drain("post_rst");
    lg("post_rst0", 0, 1, 'h81, 1, 0);
    lg("post_rst1", 1, 3, 'h83, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
